uart_hex_printer: RTL

//   Sequencer for the decoder hex-to-ASCII block. Accepts one DATA_W-bit word, walks its

---
 rtl/uart_hex_printer_pkg.sv | 30 +++
 rtl/uart_hex_printer_decoder.sv | 26 ++
 rtl/uart_hex_printer.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/uart_hex_printer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uart_hex_printer_pkg
//  Purpose  : Shared constants and state encoding for the hex printer.
//             ASCII character codes used by the sequencer and the nibble
//             decoder, plus the FSM state type. The state values are fixed
//             here so that a bench can probe the state register directly.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package uart_hex_printer_pkg;

   localparam logic [7:0] c_ascii_zero = 8'h30;   // '0'
   localparam logic [7:0] c_ascii_lc_a = 8'h61;   // 'a'
   localparam logic [7:0] c_ascii_x    = 8'h78;   // 'x'
   localparam logic [7:0] c_ascii_cr   = 8'h0D;
   localparam logic [7:0] c_ascii_lf   = 8'h0A;

   // Each non-IDLE state names the character currently presented on tx_data.
   typedef enum logic [2:0] {
      HP_IDLE  = 3'd0,
      HP_PFX0  = 3'd1,
      HP_PFX1  = 3'd2,
      HP_DIGIT = 3'd3,
      HP_CR    = 3'd4,
      HP_LF    = 3'd5
   } hp_state_e;

endpackage : uart_hex_printer_pkg
`default_nettype wire

// File: rtl/uart_hex_printer_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : uart_hex_printer_decoder
//  Purpose  : Combinational hex nibble to lowercase ASCII decoder.
//  Ports    : hex_in    in  4  nibble value 0..15
//             ascii_out out 8  '0'..'9' or 'a'..'f'
//  Revision : 1.0 - initial release
// ============================================================================
module uart_hex_printer_decoder
   import uart_hex_printer_pkg::*;
(
   input  logic [3:0] hex_in,
   output logic [7:0] ascii_out
);

   always_comb begin
      if (hex_in < 4'd10) begin
         ascii_out = c_ascii_zero + {4'h0, hex_in};
      end else begin
         // 'a' - 10 + n maps 10..15 onto 'a'..'f'
         ascii_out = (c_ascii_lc_a - 8'd10) + {4'h0, hex_in};
      end
   end

endmodule : uart_hex_printer_decoder
`default_nettype wire

// File: rtl/uart_hex_printer.sv
`default_nettype none
// ============================================================================
//  Module   : uart_hex_printer
//  Purpose  : Accepts one DATA_W-bit word and streams it as lowercase hex
//             ASCII (MSB nibble first) over a valid/ready byte interface,
//             with optional "0x" prefix and CR/LF suffix.
//  Ports    : clk       in   1       rising-edge clock
//             rst_n     in   1       asynchronous active-low reset
//             in_valid  in   1       in_data valid
//             in_ready  out  1       word can be accepted (IDLE only)
//             in_data   in   DATA_W  word to print
//             tx_valid  out  1       tx_data holds a character
//             tx_ready  in   1       character consumed this cycle
//             tx_data   out  8       ASCII character (registered)
//             busy      out  1       word in progress (= !in_ready)
//  Revision : 1.0 - initial release
// ============================================================================
module uart_hex_printer
   import uart_hex_printer_pkg::*;
#(
   parameter int DATA_W      = 32,
   parameter int PREFIX_0X   = 0,
   parameter int APPEND_CRLF = 1
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              tx_valid,
   input  logic              tx_ready,
   output logic [7:0]        tx_data,
   output logic              busy
);

   localparam int NDIG  = DATA_W / 4;
   localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;
   localparam logic [IDX_W-1:0] c_idx_top = IDX_W'(NDIG - 1);
   localparam logic [IDX_W-1:0] c_idx_one = IDX_W'(1);

   hp_state_e          state_q, state_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [DATA_W-1:0]  word_q, word_d;
   logic               tx_valid_q, tx_valid_d;
   logic [7:0]         tx_data_q, tx_data_d;
   logic               in_ready_q, in_ready_d;
   logic               busy_q, busy_d;

   logic [DATA_W-1:0]  dec_src;
   logic [IDX_W-1:0]   dec_idx;
   logic [DATA_W-1:0]  dec_shifted;
   logic [3:0]         dec_nibble;
   logic [7:0]         dec_ascii;
   logic               tx_fire;

   // The decoder always produces the *next* digit to load: on acceptance it
   // reads the top nibble straight from in_data (word_q is not loaded yet);
   // otherwise it reads word_q at the index that follows the current one.
   always_comb begin
      dec_src     = (state_q == HP_IDLE)  ? in_data : word_q;
      dec_idx     = (state_q == HP_DIGIT) ? (idx_q - c_idx_one) : c_idx_top;
      dec_shifted = dec_src >> {dec_idx, 2'b00};
      dec_nibble  = dec_shifted[3:0];
   end

   uart_hex_printer_decoder u_decoder (
      .hex_in    (dec_nibble),
      .ascii_out (dec_ascii)
   );

   assign tx_fire = tx_valid_q && tx_ready;

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      word_d     = word_q;
      tx_valid_d = tx_valid_q;
      tx_data_d  = tx_data_q;

      case (state_q)
         HP_IDLE: begin
            if (in_valid && in_ready_q) begin
               word_d     = in_data;
               idx_d      = c_idx_top;
               tx_valid_d = 1'b1;
               if (PREFIX_0X != 0) begin
                  state_d   = HP_PFX0;
                  tx_data_d = c_ascii_zero;
               end else begin
                  state_d   = HP_DIGIT;
                  tx_data_d = dec_ascii;
               end
            end
         end
         HP_PFX0: begin
            if (tx_fire) begin
               state_d   = HP_PFX1;
               tx_data_d = c_ascii_x;
            end
         end
         HP_PFX1: begin
            if (tx_fire) begin
               state_d   = HP_DIGIT;
               tx_data_d = dec_ascii;
            end
         end
         HP_DIGIT: begin
            if (tx_fire) begin
               if (idx_q == '0) begin
                  if (APPEND_CRLF != 0) begin
                     state_d   = HP_CR;
                     tx_data_d = c_ascii_cr;
                  end else begin
                     state_d    = HP_IDLE;
                     tx_valid_d = 1'b0;
                  end
               end else begin
                  idx_d     = idx_q - c_idx_one;
                  tx_data_d = dec_ascii;
               end
            end
         end
         HP_CR: begin
            if (tx_fire) begin
               state_d   = HP_LF;
               tx_data_d = c_ascii_lf;
            end
         end
         HP_LF: begin
            if (tx_fire) begin
               state_d    = HP_IDLE;
               tx_valid_d = 1'b0;
            end
         end
         default: begin
            state_d    = HP_IDLE;
            tx_valid_d = 1'b0;
         end
      endcase

      // Handshake flags are registered from the next state so they line up
      // with the state change on the same edge.
      in_ready_d = (state_d == HP_IDLE);
      busy_d     = !in_ready_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= HP_IDLE;
         idx_q      <= '0;
         word_q     <= '0;
         tx_valid_q <= 1'b0;
         tx_data_q  <= 8'h00;
         in_ready_q <= 1'b1;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         word_q     <= word_d;
         tx_valid_q <= tx_valid_d;
         tx_data_q  <= tx_data_d;
         in_ready_q <= in_ready_d;
         busy_q     <= busy_d;
      end
   end

   assign in_ready = in_ready_q;
   assign tx_valid = tx_valid_q;
   assign tx_data  = tx_data_q;
   assign busy     = busy_q;

endmodule : uart_hex_printer
`default_nettype wire
